// File: rtl/plusarg_cfg_pkg.sv
// Shared types and ASCII constants for the run-time plusarg-style config parser.
package plusarg_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_IDX,
        ST_EQ,
        ST_RADIX,
        ST_DIGITS,
        ST_COMMIT,
        ST_SKIP
    } state_t;

    typedef enum logic [1:0] {
        RADIX_BIN,
        RADIX_DEC,
        RADIX_HEX
    } radix_t;

    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_T    = 8'h54;
    localparam logic [7:0] CH_EQ   = 8'h3D;
    localparam logic [7:0] CH_B    = 8'h62;
    localparam logic [7:0] CH_D    = 8'h64;
    localparam logic [7:0] CH_H    = 8'h68;
    localparam logic [7:0] CH_US   = 8'h5F;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_NUL  = 8'h00;

    // Token separators: space, LF, CR and NUL.
    function automatic logic is_delim(input logic [7:0] c);
        return (c == CH_SP) || (c == CH_LF) || (c == CH_CR) || (c == CH_NUL);
    endfunction

    // Returns {valid, value} for 0-9, a-f, A-F; valid = 0 for anything else.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/plusarg_cfg_parser_digit_acc.sv
// Combinational digit decode and accumulator step for one ASCII byte.
module plusarg_digit_acc
    import plusarg_cfg_pkg::*;
#(
    parameter int W = 16
) (
    input  radix_t         radix,
    input  logic [7:0]     in_byte,
    input  logic [W-1:0]   acc,
    output logic           is_digit,
    output logic [W-1:0]   acc_next,
    output logic           ovf
);

    logic [4:0]   hex;
    logic [3:0]   dval;
    logic [W+3:0] acc_wide;
    logic [W+3:0] dval_wide;
    logic [W+3:0] wide;

    // Legality depends on radix; the W+4 bit intermediate exposes any carry past W.
    always_comb begin
        hex       = hex_decode(in_byte);
        dval      = hex[3:0];
        acc_wide  = {4'b0, acc};
        dval_wide = {{W{1'b0}}, dval};
        is_digit  = 1'b0;
        wide      = acc_wide;
        case (radix)
            RADIX_BIN: begin
                is_digit = hex[4] && (dval <= 4'd1);
                wide     = (acc_wide << 1) + dval_wide;
            end
            RADIX_DEC: begin
                is_digit = hex[4] && (dval <= 4'd9);
                wide     = (acc_wide << 3) + (acc_wide << 1) + dval_wide;
            end
            default: begin
                is_digit = hex[4];
                wide     = (acc_wide << 4) + dval_wide;
            end
        endcase
        if (!is_digit) begin
            wide = acc_wide;
        end
        acc_next = wide[W-1:0];
        ovf      = |wide[W+3:W];
    end

endmodule

// File: rtl/plusarg_cfg_parser.sv
// Parses "+T<k>=<r><digits>" tokens from a byte stream into per-channel config registers.
module plusarg_cfg_parser
    import plusarg_cfg_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int W          = 16,
    parameter int FIRST_WINS = 1
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic [NCH*W-1:0]   cfg_value,
    output logic [NCH-1:0]     cfg_found,
    output logic [NCH-1:0]     cfg_ovf,
    output logic [7:0]         err_cnt,
    output logic               busy
);

    state_t             state_q, state_d;
    radix_t             radix_q, radix_d;
    logic [3:0]         idx_q;
    logic [W-1:0]       acc_q;
    logic               has_dig_q;
    logic               ovf_acc_q;
    logic [NCH*W-1:0]   value_q;
    logic [NCH-1:0]     found_q;
    logic [NCH-1:0]     ovf_q;
    logic [7:0]         err_q;

    logic               accept;
    logic               byte_delim;
    logic [4:0]         idx_hex;
    logic               idx_ok;
    logic               dig_is_digit;
    logic [W-1:0]       dig_acc_next;
    logic               dig_ovf;
    logic               err_inc;
    logic               latch_idx;
    logic               latch_radix;
    logic               acc_step;

    assign in_ready   = (state_q != ST_COMMIT);
    assign busy       = (state_q != ST_IDLE);
    assign accept     = in_valid && in_ready;
    assign byte_delim = is_delim(in_data);
    assign idx_hex    = hex_decode(in_data);
    assign idx_ok     = idx_hex[4] && ({28'd0, idx_hex[3:0]} < 32'(NCH));

    assign cfg_value = value_q;
    assign cfg_found = found_q;
    assign cfg_ovf   = ovf_q;
    assign err_cnt   = err_q;

    plusarg_digit_acc #(.W(W)) u_digit_acc (
        .radix    (radix_q),
        .in_byte  (in_data),
        .acc      (acc_q),
        .is_digit (dig_is_digit),
        .acc_next (dig_acc_next),
        .ovf      (dig_ovf)
    );

    // Next-state and per-byte control strobes; every state advances only on an accepted byte except COMMIT.
    always_comb begin
        state_d     = state_q;
        radix_d     = radix_q;
        err_inc     = 1'b0;
        latch_idx   = 1'b0;
        latch_radix = 1'b0;
        acc_step    = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (in_data == CH_PLUS) state_d = ST_KEY;
                else if (!byte_delim)   state_d = ST_SKIP;
            end
            ST_KEY: if (accept) begin
                if (in_data == CH_T) state_d = ST_IDX;
                else begin state_d = ST_SKIP; err_inc = 1'b1; end
            end
            ST_IDX: if (accept) begin
                if (idx_ok) begin state_d = ST_EQ; latch_idx = 1'b1; end
                else begin state_d = ST_SKIP; err_inc = 1'b1; end
            end
            ST_EQ: if (accept) begin
                if (in_data == CH_EQ) state_d = ST_RADIX;
                else begin state_d = ST_SKIP; err_inc = 1'b1; end
            end
            ST_RADIX: if (accept) begin
                state_d     = ST_DIGITS;
                latch_radix = 1'b1;
                if (in_data == CH_B)      radix_d = RADIX_BIN;
                else if (in_data == CH_D) radix_d = RADIX_DEC;
                else if (in_data == CH_H) radix_d = RADIX_HEX;
                else begin
                    state_d     = ST_SKIP;
                    latch_radix = 1'b0;
                    err_inc     = 1'b1;
                end
            end
            ST_DIGITS: if (accept) begin
                if (in_data == CH_US) begin
                    state_d = ST_DIGITS;
                end else if (byte_delim) begin
                    if (has_dig_q) state_d = ST_COMMIT;
                    else begin state_d = ST_IDLE; err_inc = 1'b1; end
                end else if (dig_is_digit) begin
                    acc_step = 1'b1;
                end else begin
                    state_d = ST_SKIP;
                    err_inc = 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_SKIP: if (accept && byte_delim) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Parser state, latched channel/radix and the digit accumulator.
    always_ff @(posedge clk or posedge reset_l) begin
        if (reset_l) begin
            state_q   <= ST_IDLE;
            radix_q   <= RADIX_BIN;
            idx_q     <= 4'd0;
            acc_q     <= '0;
            has_dig_q <= 1'b0;
            ovf_acc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            radix_q <= radix_d;
            if (latch_idx) idx_q <= idx_hex[3:0];
            if (latch_radix) begin
                acc_q     <= '0;
                has_dig_q <= 1'b0;
                ovf_acc_q <= 1'b0;
            end else if (acc_step) begin
                acc_q     <= dig_acc_next;
                has_dig_q <= 1'b1;
                ovf_acc_q <= ovf_acc_q | dig_ovf;
            end
        end
    end

    // Commit the finished value into its channel; with FIRST_WINS an already-found channel is left untouched.
    always_ff @(posedge clk or posedge reset_l) begin
        if (reset_l) begin
            value_q <= '0;
            found_q <= '0;
            ovf_q   <= '0;
        end else if (state_q == ST_COMMIT) begin
            for (int k = 0; k < NCH; k++) begin
                if (idx_q == 4'(k) && !((FIRST_WINS != 0) && found_q[k])) begin
                    value_q[k*W +: W] <= acc_q;
                    found_q[k]        <= 1'b1;
                    ovf_q[k]          <= ovf_q[k] | ovf_acc_q;
                end
            end
        end
    end

    // Malformed-token counter, saturating at 255.
    always_ff @(posedge clk or posedge reset_l) begin
        if (reset_l) begin
            err_q <= 8'd0;
        end else if (err_inc && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_plusarg_cfg_parser.sv
// Directed bench: two parser instances (first-wins and last-wins) fed the same byte stream.
module tb_plusarg_cfg_parser;

    localparam int NCH = 4;
    localparam int W   = 16;

    logic             clk = 1'b0;
    logic             reset_l;
    logic             in_valid;
    logic [7:0]       in_data;

    logic             in_ready,    in_ready_lw;
    logic [NCH*W-1:0] cfg_value,   cfg_value_lw;
    logic [NCH-1:0]   cfg_found,   cfg_found_lw;
    logic [NCH-1:0]   cfg_ovf,     cfg_ovf_lw;
    logic [7:0]       err_cnt,     err_cnt_lw;
    logic             busy,        busy_lw;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int stall_cnt = 0;

    plusarg_cfg_parser #(.NCH(NCH), .W(W), .FIRST_WINS(1)) dut (
        .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .cfg_value(cfg_value), .cfg_found(cfg_found),
        .cfg_ovf(cfg_ovf), .err_cnt(err_cnt), .busy(busy)
    );

    plusarg_cfg_parser #(.NCH(NCH), .W(W), .FIRST_WINS(0)) dut_lw (
        .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_lw), .cfg_value(cfg_value_lw), .cfg_found(cfg_found_lw),
        .cfg_ovf(cfg_ovf_lw), .err_cnt(err_cnt_lw), .busy(busy_lw)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the byte on the bus until the parser takes it; stalled cycles are counted.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 8 && !done; n++) begin
            if (in_ready) done = 1'b1;
            else stall_cnt++;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    // Streams a whole string with in_valid held high throughout, then drops in_valid.
    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset_l  = 1'b1;
        wait_cycles(2);
        reset_l  = 1'b0;
        wait_cycles(1);
    endtask

    initial begin
        reset_l  = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        wait_cycles(2);

        $display("[TB] reset state");
        checkOutput("rst_value",    64'(cfg_value), 64'd0);
        checkOutput("rst_found",    64'(cfg_found), 64'd0);
        checkOutput("rst_ovf",      64'(cfg_ovf),   64'd0);
        checkOutput("rst_err",      64'(err_cnt),   64'd0);
        checkOutput("rst_in_ready", 64'(in_ready),  64'd1);
        checkOutput("rst_busy",     64'(busy),      64'd0);
        reset_l = 1'b0;
        wait_cycles(1);

        $display("[TB] basic decode");
        applyStimulus("+T0=b101 +T1=d1234 +T2=hBEEF\n");
        wait_cycles(2);
        checkOutput("basic_v0",    64'(cfg_value[15:0]),  64'd5);
        checkOutput("basic_v1",    64'(cfg_value[31:16]), 64'd1234);
        checkOutput("basic_v2",    64'(cfg_value[47:32]), 64'hBEEF);
        checkOutput("basic_v3",    64'(cfg_value[63:48]), 64'd0);
        checkOutput("basic_found", 64'(cfg_found),        64'b0111);
        checkOutput("basic_err",   64'(err_cnt),          64'd0);
        checkOutput("basic_lw_v0", 64'(cfg_value_lw[15:0]), 64'd5);
        checkOutput("basic_busy",  64'(busy),             64'd0);

        $display("[TB] first-wins versus last-wins");
        do_reset();
        applyStimulus("+T0=d7 +T0=d9 ");
        wait_cycles(2);
        checkOutput("fw_v0",     64'(cfg_value[15:0]),    64'd7);
        checkOutput("lw_v0",     64'(cfg_value_lw[15:0]), 64'd9);
        checkOutput("fw_err",    64'(err_cnt),            64'd0);
        checkOutput("lw_err",    64'(err_cnt_lw),         64'd0);
        checkOutput("fw_found",  64'(cfg_found),          64'b0001);

        $display("[TB] overflow");
        applyStimulus("+T3=d70000 ");
        wait_cycles(2);
        checkOutput("ovf_v3",    64'(cfg_value[63:48]), 64'd4464);
        checkOutput("ovf_flag",  64'(cfg_ovf),          64'b1000);
        checkOutput("ovf_found", 64'(cfg_found),        64'b1001);

        $display("[TB] malformed tokens");
        do_reset();
        applyStimulus("+T9=d1 +X0=d1 +T0=q1 +T0=d ");
        wait_cycles(2);
        checkOutput("bad_err",   64'(err_cnt),   64'd4);
        checkOutput("bad_found", 64'(cfg_found), 64'd0);
        applyStimulus("junk ");
        wait_cycles(2);
        checkOutput("junk_err",  64'(err_cnt),   64'd4);
        checkOutput("junk_busy", 64'(busy),      64'd0);

        $display("[TB] backpressure");
        stall_cnt = 0;
        applyStimulus("+T1=h_ff +T2=d5 ");
        checkOutput("bp_ready_low", 64'(in_ready),  64'd0);
        checkOutput("bp_stalls",    64'(stall_cnt), 64'd1);
        wait_cycles(1);
        checkOutput("bp_ready_high", 64'(in_ready), 64'd1);
        wait_cycles(1);
        checkOutput("bp_v1",    64'(cfg_value[31:16]), 64'h00FF);
        checkOutput("bp_v2",    64'(cfg_value[47:32]), 64'd5);
        checkOutput("bp_found", 64'(cfg_found),        64'b0110);
        checkOutput("bp_err",   64'(err_cnt),          64'd4);

        $display("[TB] reset mid-token");
        applyStimulus("+T2=d12");
        checkOutput("mid_busy", 64'(busy), 64'd1);
        #2;
        reset_l = 1'b1;
        #1;
        checkOutput("mid_value", 64'(cfg_value), 64'd0);
        checkOutput("mid_found", 64'(cfg_found), 64'd0);
        checkOutput("mid_err",   64'(err_cnt),   64'd0);
        checkOutput("mid_idle",  64'(busy),      64'd0);
        wait_cycles(1);
        reset_l = 1'b0;
        wait_cycles(1);
        applyStimulus("3 ");
        wait_cycles(2);
        checkOutput("post_found", 64'(cfg_found), 64'd0);
        checkOutput("post_err",   64'(err_cnt),   64'd0);
        checkOutput("post_value", 64'(cfg_value), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
